lifm_partition_scheduler: RTL and testbench
===========================================

LIFM_PARTITION_SCHEDULER -- requirements
Module: lifm_partition_scheduler

Interface
REQ-001 SHALL have parameters: WORD_WIDTH 8, kidx/word width; RSIZ_WIDTH 2, rowsize width; ADDR_WIDTH 8, LIFM row memory address width; TIMEOUT 1023, maximum cycles spent waiting for rc_valid.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  reset.
- start  in  1  begin a job.
- num_kidx  in  WORD_WIDTH  total LIFM rows K.
- part_rsiz  in  RSIZ_WIDTH  nominal partition row size, 2 or 3.
- busy  out  1  job in progress.
- done  out  1  one-cycle end-of-job pulse.
- error  out  1  sticky job error flag.
- rd_en  out  1  LIFM row memory read strobe.
- rd_addr  out  ADDR_WIDTH  LIFM row address; data returns 1 cycle later.
- rc_enable  out  1  redundancy controller start pulse.
- rc_row_valid  out  1  row/kidx presented to the controller.
- rc_kidx  out  WORD_WIDTH  kernel index of the presented row.
- rc_rsiz  out  RSIZ_WIDTH  rowsize of the current partition.
- rc_valid  in  1  controller output valid.
- wr_en  out  1  result write strobe.
- wr_addr  out  WORD_WIDTH  partition index being written.
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL implement the FSM IDLE, PLAN, START, STREAM, WAIT, WRITE, FIN.
REQ-005 In IDLE, start=1 SHALL latch num_kidx and part_rsiz, clear base and part_cnt, set busy, and go to PLAN; start outside IDLE SHALL be ignored.
REQ-006 If latched num_kidx < 2, the FSM SHALL go IDLE->FIN, set error, and issue no reads.
REQ-007 PLAN (1 cycle): remaining r = K - base; size = r if r<=3, 2 if r==4, else part_rsiz. A trailing 1-row partition SHALL never occur.
REQ-008 START (1 cycle) SHALL drive rc_enable=1, rc_rsiz=size, rd_en=1, rd_addr=base.
REQ-009 STREAM SHALL last exactly size cycles; in cycle i it SHALL drive rc_row_valid=1 and rc_kidx=base+i, and rd_en=1 with rd_addr=base+i+1 only for i<size-1.
REQ-010 rc_rsiz SHALL hold from START until WRITE ends.
REQ-011 After STREAM the FSM SHALL go to WAIT, where a wait counter increments each cycle.
REQ-012 rc_valid=1 in WAIT SHALL go to WRITE; wait counter reaching TIMEOUT SHALL set error and go to FIN.
REQ-013 rc_valid outside WAIT SHALL be ignored.
REQ-014 WRITE (1 cycle) SHALL drive wr_en=1 with wr_addr=part_cnt, then set base+=size and part_cnt+=1.
REQ-015 From WRITE the FSM SHALL go to PLAN if the new base < K, else FIN.
REQ-016 FIN (1 cycle) SHALL pulse done=1, clear busy, and go to IDLE.
REQ-017 error SHALL hold until the next accepted start.
REQ-018 Outside the cycles named above, rd_en, rc_enable, rc_row_valid and wr_en SHALL be 0.
REQ-019 Address/kidx arithmetic SHALL be modulo 2^WORD_WIDTH; K=255 SHALL complete without wrap.
REQ-020 part_rsiz values 0 or 1 SHALL be treated as 2.

Reset
REQ-021 reset=1 SHALL force IDLE and set busy, done, error, rd_en, rc_enable, rc_row_valid, wr_en=0 and rd_addr, rc_kidx, rc_rsiz, wr_addr, base, part_cnt, wait counter=0 on the next clk edge, including mid-job.
REQ-022 An in-flight rc_valid during or after reset SHALL not produce wr_en.

Verification
REQ-023 K=6, part_rsiz=3, rc_valid 5 cycles after each STREAM -> two partitions of rsiz 3, rc_kidx 0,1,2 then 3,4,5, wr_addr 0,1, one done pulse, error=0.
REQ-024 K=7, part_rsiz=3 -> partition sizes 3,2,2 with kidx bases 0,3,5; three wr_en pulses.
REQ-025 K=3, part_rsiz=2 -> single partition rsiz 3; rd_addr sequence 0,1,2 on consecutive cycles; rc_kidx 0,1,2 each one cycle after its read.
REQ-026 K=1 -> done one cycle after leaving IDLE, error=1, no rd_en/rc_enable.
REQ-027 K=4, rc_valid never asserted -> error=1 and done after TIMEOUT wait cycles; a new start clears error.
REQ-028 reset asserted during STREAM of partition 1 (K=9) -> all outputs 0 next cycle, start accepted afterward restarts at kidx 0; extra start pulses while busy -> no effect.

Source files
------------

// File: rtl/lifm_partition_scheduler.sv
// LIFM partition scheduler.
// Splits K LIFM rows into partitions of 2 or 3 rows and streams each one to
// the redundancy controller. Each partition's result is written at its
// partition index. The partition plan never leaves a trailing 1-row partition.
module lifm_partition_scheduler #(
    parameter int WORD_WIDTH = 8,
    parameter int RSIZ_WIDTH = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] num_kidx,
    input  logic [RSIZ_WIDTH-1:0] part_rsiz,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rc_enable,
    output logic                  rc_row_valid,
    output logic [WORD_WIDTH-1:0] rc_kidx,
    output logic [RSIZ_WIDTH-1:0] rc_rsiz,
    input  logic                  rc_valid,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] wr_addr
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PLAN, S_START, S_STREAM, S_WAIT, S_WRITE, S_FIN
    } state_t;

    state_t                state, state_nx;
    logic [WORD_WIDTH-1:0] k_lat, base, part_cnt;
    logic [RSIZ_WIDTH-1:0] rsiz_lat, size, idx;
    logic [WCW-1:0]        wait_cnt;
    logic                  error_r;

    logic [WORD_WIDTH-1:0] remain, kidx_cur, base_nx;
    logic [RSIZ_WIDTH-1:0] nom_rsiz, plan_size;
    logic                  last_row, wait_expired;

    // Partition planning and streaming arithmetic. All of it wraps modulo 2^WORD_WIDTH.
    // A remainder of 4 is split as 2+2. Splitting it as 3+1 would leave a single row.
    always_comb begin
        remain       = k_lat - base;
        nom_rsiz     = (rsiz_lat < RSIZ_WIDTH'(2)) ? RSIZ_WIDTH'(2) : rsiz_lat;
        if (remain <= WORD_WIDTH'(3))
            plan_size = RSIZ_WIDTH'(remain);
        else if (remain == WORD_WIDTH'(4))
            plan_size = RSIZ_WIDTH'(2);
        else
            plan_size = nom_rsiz;
        kidx_cur     = base + WORD_WIDTH'(idx);
        base_nx      = base + WORD_WIDTH'(size);
        last_row     = (idx == size - RSIZ_WIDTH'(1));
        wait_expired = (wait_cnt == WCW'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic and strobe/address outputs, decoded from the current state.
    always_comb begin
        state_nx     = state;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        error        = error_r;
        rd_en        = 1'b0;
        rd_addr      = '0;
        rc_enable    = 1'b0;
        rc_row_valid = 1'b0;
        rc_kidx      = '0;
        rc_rsiz      = '0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = (num_kidx < WORD_WIDTH'(2)) ? S_FIN : S_PLAN;
            end
            S_PLAN: state_nx = S_START;
            S_START: begin
                rc_enable = 1'b1;
                rc_rsiz   = size;
                rd_en     = 1'b1;
                rd_addr   = ADDR_WIDTH'(base);
                state_nx  = S_STREAM;
            end
            S_STREAM: begin
                rc_row_valid = 1'b1;
                rc_kidx      = kidx_cur;
                rc_rsiz      = size;
                if (!last_row) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_WIDTH'(kidx_cur + WORD_WIDTH'(1));
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                rc_rsiz = size;
                if (rc_valid)          state_nx = S_WRITE;
                else if (wait_expired) state_nx = S_FIN;
            end
            S_WRITE: begin
                wr_en    = 1'b1;
                wr_addr  = part_cnt;
                rc_rsiz  = size;
                state_nx = (base_nx < k_lat) ? S_PLAN : S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Job bookkeeping: latched job inputs, partition cursor, row/wait counters and the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_lat    <= '0;
            rsiz_lat <= '0;
            base     <= '0;
            part_cnt <= '0;
            size     <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            error_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_lat    <= num_kidx;
                        rsiz_lat <= part_rsiz;
                        base     <= '0;
                        part_cnt <= '0;
                        error_r  <= (num_kidx < WORD_WIDTH'(2));
                    end
                end
                S_PLAN: begin
                    size <= plan_size;
                    idx  <= '0;
                end
                S_STREAM: begin
                    idx      <= last_row ? '0 : idx + RSIZ_WIDTH'(1);
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (!rc_valid) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                        if (wait_expired) error_r <= 1'b1;
                    end
                end
                S_WRITE: begin
                    base     <= base_nx;
                    part_cnt <= part_cnt + WORD_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lifm_partition_scheduler.sv
// Testbench for lifm_partition_scheduler.
// Each job vector gives K, the nominal row size, the controller response delay
// and the hand-computed partition plan. Hand-written sequences cover the
// mid-job reset and the timeout.
module tb_lifm_partition_scheduler;

    localparam int TMO   = 1023;
    localparam int NEVER = 100000;

    logic       clk, reset, start, rc_valid;
    logic [7:0] num_kidx;
    logic [1:0] part_rsiz;
    logic       busy, done, error, rd_en, rc_enable, rc_row_valid, wr_en;
    logic [7:0] rd_addr, rc_kidx, wr_addr;
    logic [1:0] rc_rsiz;

    lifm_partition_scheduler #(.WORD_WIDTH(8), .RSIZ_WIDTH(2), .ADDR_WIDTH(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .num_kidx(num_kidx), .part_rsiz(part_rsiz),
        .busy(busy), .done(done), .error(error), .rd_en(rd_en), .rd_addr(rd_addr),
        .rc_enable(rc_enable), .rc_row_valid(rc_row_valid), .rc_kidx(rc_kidx), .rc_rsiz(rc_rsiz),
        .rc_valid(rc_valid), .wr_en(wr_en), .wr_addr(wr_addr)
    );

    typedef struct {
        int k; int rsiz; int dly; bit noise; bit extra; bit err;
        int nen; int nwr; int rows; bit tmo; logic [3:0][3:0] sz;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int dly = NEVER;
    bit noise = 0, force_rv = 0;
    int rd_q[$], en_q[$], base_q[$], kidx_q[$], kcyc_q[$], wr_q[$];
    int rd_cyc[256];
    int done_cnt = 0, done_cyc = 0, last_rv = 0, cur_rsiz = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int k, int rsiz, int d, bit nz, bit ex, bit er, int nen,
                                int nwr, int rows, bit tmo, int s0, int s1, int s2, int s3);
        vec_t v;
        v.k = k; v.rsiz = rsiz; v.dly = d; v.noise = nz; v.extra = ex; v.err = er;
        v.nen = nen; v.nwr = nwr; v.rows = rows; v.tmo = tmo;
        v.sz[0] = 4'(s0); v.sz[1] = 4'(s1); v.sz[2] = 4'(s2); v.sz[3] = 4'(s3);
        return v;
    endfunction

    // Event recorder, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_en) begin rd_q.push_back(int'(rd_addr)); rd_cyc[rd_addr] = cyc; end
            if (rc_enable) begin
                en_q.push_back(int'(rc_rsiz)); base_q.push_back(int'(rd_addr)); cur_rsiz = int'(rc_rsiz);
            end
            if (rc_row_valid) begin
                kidx_q.push_back(int'(rc_kidx)); kcyc_q.push_back(cyc); last_rv = cyc;
            end
            if (wr_en) begin
                wr_q.push_back(int'(wr_addr));
                chk("rsiz_hold_at_write", int'(rc_rsiz), cur_rsiz);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    // Controller model: answers dly cycles into WAIT; optional stray pulses outside WAIT.
    initial begin
        int gap;
        bit prev_rv;
        gap = -1; prev_rv = 0; rc_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            rc_valid = 1'b0;
            if (reset) gap = -1;
            else if (prev_rv && !rc_row_valid) gap = 0;
            else if (gap >= 0) gap++;
            if (gap >= 0 && gap == dly) begin rc_valid = 1'b1; gap = -1; end
            if (noise && (rc_enable || rc_row_valid)) rc_valid = 1'b1;
            if (force_rv) rc_valid = 1'b1;
            prev_rv = rc_row_valid;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rc_enable"}, int'(rc_enable), 0);
        chk({tag, "_rc_row_valid"}, int'(rc_row_valid), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_rc_kidx"}, int'(rc_kidx), 0);
        chk({tag, "_rc_rsiz"}, int'(rc_rsiz), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    endtask

    task automatic clear_log();
        rd_q.delete(); en_q.delete(); base_q.delete(); kidx_q.delete(); kcyc_q.delete(); wr_q.delete();
        foreach (rd_cyc[i]) rd_cyc[i] = -1;
        done_cnt = 0;
    endtask

    task automatic run_job(input string tag, input vec_t v);
        int n, bad_k, bad_r, bad_w, bad_t, exp_base;
        clear_log();
        dly = v.dly; noise = v.noise;
        @(posedge clk); #1;
        num_kidx = 8'(v.k); part_rsiz = 2'(v.rsiz); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (v.err && v.k < 2) begin
            chk({tag, "_first_done"}, int'(done), 1);
            chk({tag, "_first_error"}, int'(error), 1);
        end else begin
            chk({tag, "_first_busy"}, int'(busy), 1);
            chk({tag, "_first_error"}, int'(error), 0);
        end
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            if (v.extra && (n == 3 || n == 7)) begin start = 1'b1; num_kidx = 8'd2; end
            else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_done_within_budget"}, int'(n < 5000), 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_error"}, int'(error), int'(v.err));
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_n_enable"}, en_q.size(), v.nen);
        chk({tag, "_n_write"}, wr_q.size(), v.nwr);
        chk({tag, "_n_rows"}, kidx_q.size(), v.rows);
        chk({tag, "_n_reads"}, rd_q.size(), v.rows);
        exp_base = 0;
        for (int i = 0; i < 4 && i < v.nen && i < en_q.size(); i++) begin
            chk($sformatf("%s_rsiz%0d", tag, i), en_q[i], int'(v.sz[i]));
            chk($sformatf("%s_base%0d", tag, i), base_q[i], exp_base);
            exp_base += int'(v.sz[i]);
        end
        bad_k = -1; bad_r = -1; bad_w = -1; bad_t = 0;
        foreach (kidx_q[i]) begin
            if (kidx_q[i] != i && bad_k < 0) bad_k = i;
            if (rd_cyc[kidx_q[i] & 255] != kcyc_q[i] - 1) bad_t++;
        end
        foreach (rd_q[i])  if (rd_q[i] != i && bad_r < 0) bad_r = i;
        foreach (wr_q[i])  if (wr_q[i] != i && bad_w < 0) bad_w = i;
        chk({tag, "_kidx_seq_first_bad"}, bad_k, -1);
        chk({tag, "_rd_seq_first_bad"}, bad_r, -1);
        chk({tag, "_wr_seq_first_bad"}, bad_w, -1);
        chk({tag, "_read_leads_row_by_1"}, bad_t, 0);
        if (v.tmo) chk({tag, "_timeout_len"}, done_cyc - last_rv, TMO + 1);
    endtask

    initial begin
        vec_t tbl[13];
        vec_t post;
        int n;
        tbl[0]  = mk(6,   3, 5,     0, 0, 0, 2,  2,  6,   0, 3, 3, 0, 0);
        tbl[1]  = mk(7,   3, 1,     1, 0, 0, 3,  3,  7,   0, 3, 2, 2, 0);
        tbl[2]  = mk(3,   2, 0,     0, 0, 0, 1,  1,  3,   0, 3, 0, 0, 0);
        tbl[3]  = mk(2,   3, 2,     0, 0, 0, 1,  1,  2,   0, 2, 0, 0, 0);
        tbl[4]  = mk(5,   2, 0,     0, 0, 0, 2,  2,  5,   0, 2, 3, 0, 0);
        tbl[5]  = mk(8,   0, 3,     0, 1, 0, 4,  4,  8,   0, 2, 2, 2, 2);
        tbl[6]  = mk(11,  3, 0,     1, 0, 0, 4,  4,  11,  0, 3, 3, 3, 2);
        tbl[7]  = mk(9,   1, 1,     0, 0, 0, 4,  4,  9,   0, 2, 2, 2, 3);
        tbl[8]  = mk(1,   3, 0,     0, 0, 1, 0,  0,  0,   0, 0, 0, 0, 0);
        tbl[9]  = mk(0,   2, 0,     0, 0, 1, 0,  0,  0,   0, 0, 0, 0, 0);
        tbl[10] = mk(4,   3, NEVER, 0, 0, 1, 1,  0,  2,   1, 2, 0, 0, 0);
        tbl[11] = mk(2,   2, 0,     0, 0, 0, 1,  1,  2,   0, 2, 0, 0, 0);
        tbl[12] = mk(255, 3, 1,     0, 0, 0, 85, 85, 255, 0, 3, 3, 3, 3);
        post    = mk(9,   3, 2,     1, 1, 0, 3,  3,  9,   0, 3, 3, 3, 0);

        reset = 1'b1; start = 1'b0; num_kidx = '0; part_rsiz = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("in_reset");
        reset = 1'b0;
        @(posedge clk); #1;
        chk_zero("after_reset");

        for (int i = 0; i < 13; i++) run_job($sformatf("v%0d_k%0d", i, tbl[i].k), tbl[i]);

        // Mid-job reset while streaming partition 1, with rc_valid held high around it.
        clear_log();
        dly = 3; noise = 0;
        @(posedge clk); #1;
        num_kidx = 8'd9; part_rsiz = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(wr_q.size() == 1 && rc_row_valid) && n < 200) begin @(posedge clk); #1; n++; end
        chk("rst_reached_part1_stream", int'(n < 200), 1);
        reset = 1'b1; force_rv = 1'b1;
        @(posedge clk); #1;
        chk_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_reset_wr_en", int'(wr_en), 0);
            chk("post_reset_busy", int'(busy), 0);
        end
        force_rv = 1'b0;
        chk("post_reset_writes", wr_q.size(), 1);
        run_job("restart_k9", post);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
